seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pattern_tx.sv | 124 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures a pattern of up to WIDTH bits and shifts it out
// MSB-first, repeating it load_repeat extra times, then pulses done for one cycle.
module seq_pattern_tx #(
  parameter  int WIDTH = 8,
  parameter  int RPT_W = 4,
  localparam int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [RPT_W-1:0] load_repeat,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pat;
  logic [WIDTH-1:0] r_shift;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [RPT_W-1:0] r_rpt;
  logic             r_out;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;

  logic [LEN_W-1:0] w_len_eff;
  logic [WIDTH-1:0] w_aligned;

  // Out-of-range lengths fall back to the full width; the pattern is left-aligned so
  // the first bit to send always sits in the MSB of the shift register.
  assign w_len_eff = ((load_len == {LEN_W{1'b0}}) || (load_len > LEN_W'(WIDTH)))
                     ? LEN_W'(WIDTH) : load_len;
  assign w_aligned = load_data << (LEN_W'(WIDTH) - w_len_eff);

  assign load_ready = (r_state == ST_IDLE);
  assign out        = r_out;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign done       = r_done;

  // Transfer FSM with registered serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pat       <= {WIDTH{1'b0}};
      r_shift     <= {WIDTH{1'b0}};
      r_len       <= {LEN_W{1'b0}};
      r_cnt       <= {LEN_W{1'b0}};
      r_rpt       <= {RPT_W{1'b0}};
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load_valid) begin
            r_state     <= ST_SHIFT;
            r_pat       <= w_aligned;
            r_shift     <= w_aligned << 1;
            r_len       <= w_len_eff;
            r_cnt       <= w_len_eff - LEN_W'(1);
            r_rpt       <= load_repeat;
            r_out       <= w_aligned[WIDTH-1];
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end else begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (r_cnt != {LEN_W{1'b0}}) begin
            r_cnt   <= r_cnt - LEN_W'(1);
            r_out   <= r_shift[WIDTH-1];
            r_shift <= r_shift << 1;
          end else if (r_rpt != {RPT_W{1'b0}}) begin
            // Reload from the saved copy so the repeat starts without a gap cycle.
            r_rpt   <= r_rpt - RPT_W'(1);
            r_cnt   <= r_len - LEN_W'(1);
            r_out   <= r_pat[WIDTH-1];
            r_shift <= r_pat << 1;
          end else begin
            r_state     <= ST_DONE;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_out       <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out       <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with a 101 Moore detector on the serial output.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_data = 8'h00;
  logic [3:0] load_len = 4'd0;
  logic [3:0] load_repeat = 4'd0;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  seq_pattern_tx #(.WIDTH(8), .RPT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_len    (load_len),
    .load_repeat (load_repeat),
    .out         (out),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // 101 Moore detector, overlapping, restarted whenever out_valid drops.
  typedef enum logic [1:0] {D_S0, D_S1, D_S10, D_S101} det_t;
  det_t det_state;
  int   det_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) det_state <= D_S0;
    else if (!out_valid) det_state <= D_S0;
    else begin
      case (det_state)
        D_S0:    det_state <= out ? D_S1 : D_S0;
        D_S1:    det_state <= out ? D_S1 : D_S10;
        D_S10:   det_state <= out ? D_S101 : D_S0;
        D_S101:  det_state <= out ? D_S1 : D_S10;
        default: det_state <= D_S0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (det_state == D_S101) det_cnt = det_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_vec++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
    n_vec++; if (out !== 1'b0)        begin n_err++; $display("FAIL reset_out got %b want 0", out); end
    n_vec++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0)       begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [2:0] exp;
    exp = 3'b101;
    det_cnt = 0;
    load_valid = 1'b1; load_data = 8'b0000_0101; load_len = 4'd3; load_repeat = 4'd0;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (out !== exp[2-i] || out_valid !== 1'b1 || busy !== 1'b1) begin
        n_err++; $display("FAIL basic_bit%0d got out=%b v=%b busy=%b want out=%b v=1 busy=1", i, out, out_valid, busy, exp[2-i]);
      end
      tick();
    end
    n_vec++; if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || out !== 1'b0) begin
      n_err++; $display("FAIL basic_done got done=%b busy=%b v=%b out=%b want 1 1 0 0", done, busy, out_valid, out);
    end
    tick();
    n_vec++; if (load_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_idle got ready=%b done=%b busy=%b want 1 0 0", load_ready, done, busy);
    end
    n_vec++; if (det_cnt !== 1) begin n_err++; $display("FAIL basic_detect got %0d want 1", det_cnt); end
  endtask

  task automatic test_repeat();
    logic [5:0] exp;
    exp = 6'b101010;
    load_valid = 1'b1; load_data = 8'b0000_0010; load_len = 4'd2; load_repeat = 4'd2;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (out !== exp[5-i] || out_valid !== 1'b1 || done !== 1'b0) begin
        n_err++; $display("FAIL repeat_bit%0d got out=%b v=%b done=%b want out=%b v=1 done=0", i, out, out_valid, done, exp[5-i]);
      end
      tick();
    end
    n_vec++; if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL repeat_done got done=%b v=%b want 1 0", done, out_valid);
    end
    tick();
    n_vec++; if (done !== 1'b0 || load_ready !== 1'b1) begin
      n_err++; $display("FAIL repeat_single_pulse got done=%b ready=%b want 0 1", done, load_ready);
    end
  endtask

  task automatic test_len_bounds();
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    exp_a = 8'hA5;
    exp_b = 8'h3C;
    load_valid = 1'b1; load_data = 8'hA5; load_len = 4'd0; load_repeat = 4'd0;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (out !== exp_a[7-i] || out_valid !== 1'b1) begin
        n_err++; $display("FAIL len0_bit%0d got out=%b v=%b want out=%b v=1", i, out, out_valid, exp_a[7-i]);
      end
      tick();
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL len0_done got %b want 1", done); end
    tick();
    load_valid = 1'b1; load_data = 8'h3C; load_len = 4'd12; load_repeat = 4'd0;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (out !== exp_b[7-i] || out_valid !== 1'b1) begin
        n_err++; $display("FAIL lenbig_bit%0d got out=%b v=%b want out=%b v=1", i, out, out_valid, exp_b[7-i]);
      end
      tick();
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL lenbig_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_ignore_load();
    logic [7:0] exp;
    exp = 8'hC3;
    load_valid = 1'b1; load_data = 8'hC3; load_len = 4'd8; load_repeat = 4'd0;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        load_valid = 1'b1; load_data = 8'h00; load_len = 4'd2; load_repeat = 4'd3;
        n_vec++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL ignore_ready got %b want 0", load_ready); end
      end else begin
        load_valid = 1'b0;
      end
      n_vec++; if (out !== exp[7-i] || out_valid !== 1'b1) begin
        n_err++; $display("FAIL ignore_bit%0d got out=%b v=%b want out=%b v=1", i, out, out_valid, exp[7-i]);
      end
      tick();
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL ignore_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    logic       exp_v;
    int         p;
    exp = 5'b10101;
    det_cnt = 0;
    load_valid = 1'b1; load_data = 8'h15; load_len = 4'd5; load_repeat = 4'd0;
    tick();
    for (int c = 1; c <= 12; c++) begin
      exp_v = (c <= 5) || (c >= 8);
      p = (c <= 5) ? c - 1 : c - 8;
      n_vec++; if (out_valid !== exp_v) begin
        n_err++; $display("FAIL b2b_valid_c%0d got %b want %b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        n_vec++; if (out !== exp[4-p]) begin
          n_err++; $display("FAIL b2b_bit_c%0d got %b want %b", c, out, exp[4-p]);
        end
      end
      if (c == 12) load_valid = 1'b0;
      tick();
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done got %b want 1", done); end
    tick();
    n_vec++; if (load_ready !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle got ready=%b done=%b want 1 0", load_ready, done);
    end
    n_vec++; if (det_cnt !== 4) begin n_err++; $display("FAIL b2b_overlap_detect got %0d want 4", det_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    exp = 3'b110;
    load_valid = 1'b1; load_data = 8'h05; load_len = 4'd3; load_repeat = 4'd0;
    tick();
    load_valid = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_vec++; if (out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_async got out=%b v=%b busy=%b ready=%b want 0 0 0 1", out, out_valid, busy, load_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (done !== 1'b0 || out_valid !== 1'b0) begin
        n_err++; $display("FAIL midrst_hold%0d got done=%b v=%b want 0 0", i, done, out_valid);
      end
    end
    rst = 1'b1;
    load_valid = 1'b1; load_data = 8'h06; load_len = 4'd3; load_repeat = 4'd0;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (out !== exp[2-i] || out_valid !== 1'b1) begin
        n_err++; $display("FAIL midrst_reload_bit%0d got out=%b v=%b want out=%b v=1", i, out, out_valid, exp[2-i]);
      end
      tick();
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL midrst_reload_done got %b want 1", done); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_len_bounds();
    test_ignore_load();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
